// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// holding each bit for D clocks and repeating the whole pattern R times.
module pattern_tx #(
    parameter int WIDTH = 7,
    parameter int DIV_W = 16,
    parameter int RPT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [DIV_W-1:0] bit_div,
    input  logic [RPT_W-1:0] repeat_cnt,
    output logic             seq_signal,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_lat;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] bit_cnt;
    logic [RPT_W-1:0] rpt_left;
    logic [IW-1:0]    bit_idx;
    logic             end_bit;
    logic             last_bit;
    logic             last_rep;

    // bit_cnt counts 0..D-1 within a bit; rpt_left holds repetitions still to send
    assign sh_next  = shreg << 1;
    assign end_bit  = (bit_cnt == div_lat - DIV_W'(1));
    assign last_bit = (bit_idx == LAST_IDX);
    assign last_rep = (rpt_left == RPT_W'(1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            pat_lat    <= '0;
            shreg      <= '0;
            div_lat    <= '0;
            bit_cnt    <= '0;
            rpt_left   <= '0;
            bit_idx    <= '0;
            seq_signal <= 1'b0;
            seq_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        pat_lat    <= pattern_in;
                        shreg      <= pattern_in;
                        div_lat    <= (bit_div == '0) ? DIV_W'(1) : bit_div;
                        rpt_left   <= (repeat_cnt == '0) ? RPT_W'(1) : repeat_cnt;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        seq_signal <= pattern_in[WIDTH-1];
                        seq_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state      <= IDLE;
                        seq_signal <= 1'b0;
                        seq_valid  <= 1'b0;
                        busy       <= 1'b0;
                    end else if (!end_bit) begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end else begin
                        bit_cnt <= '0;
                        if (!last_bit) begin
                            shreg      <= sh_next;
                            seq_signal <= sh_next[WIDTH-1];
                            bit_idx    <= bit_idx + IW'(1);
                        end else if (!last_rep) begin
                            // seamless reload: next repetition's MSB follows directly
                            shreg      <= pat_lat;
                            seq_signal <= pat_lat[WIDTH-1];
                            bit_idx    <= '0;
                            rpt_left   <= rpt_left - RPT_W'(1);
                        end else begin
                            state      <= IDLE;
                            seq_signal <= 1'b0;
                            seq_valid  <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: expected bitstreams are built from the pattern, D and R
// as a flat queue (one entry per clock) and compared cycle by cycle.
module tb_pattern_tx;

    localparam int W  = 7;
    localparam int DW = 8;
    localparam int RW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          start, abort;
    logic [W-1:0]  pattern_in;
    logic [DW-1:0] bit_div;
    logic [RW-1:0] repeat_cnt;
    logic          seq_signal, seq_valid, busy, done;

    int vectors = 0;
    int errors  = 0;

    pattern_tx #(.WIDTH(W), .DIV_W(DW), .RPT_W(RW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .abort      (abort),
        .pattern_in (pattern_in),
        .bit_div    (bit_div),
        .repeat_cnt (repeat_cnt),
        .seq_signal (seq_signal),
        .seq_valid  (seq_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Starts a transfer from IDLE and checks every cycle through the done cycle.
    // Returns in the done cycle, so a caller may issue the next start immediately.
    task automatic expect_xfer(input logic [W-1:0] pat, input logic [DW-1:0] d,
                               input logic [RW-1:0] r, input bit disturb, input string name);
        bit exp_q[$];
        int dd, rr;
        dd = (d == 0) ? 1 : int'(d);
        rr = (r == 0) ? 1 : int'(r);
        for (int k = 0; k < rr; k++)
            for (int i = W - 1; i >= 0; i--)
                for (int c = 0; c < dd; c++)
                    exp_q.push_back(pat[i]);
        start = 1'b1; pattern_in = pat; bit_div = d; repeat_cnt = r;
        step();
        start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            vectors++;
            if ({busy, seq_valid, seq_signal, done} !== {1'b1, 1'b1, exp_q[j], 1'b0}) begin
                errors++;
                $display("FAIL %s cyc %0d: busy/valid/sig/done got %b%b%b%b want 11%b0",
                         name, j, busy, seq_valid, seq_signal, done, exp_q[j]);
            end
            if (disturb) begin
                if (j < exp_q.size() - 1) begin
                    start      = 1'($urandom_range(0, 1));
                    pattern_in = W'($urandom);
                    bit_div    = DW'($urandom);
                    repeat_cnt = RW'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            step();
        end
        vectors++;
        if ({busy, seq_valid, seq_signal, done} !== 4'b0001) begin
            errors++;
            $display("FAIL %s done cycle: busy/valid/sig/done got %b%b%b%b want 0001",
                     name, busy, seq_valid, seq_signal, done);
        end
    endtask

    task automatic expect_quiet(input string name);
        vectors++;
        if ({busy, seq_valid, seq_signal, done} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: busy/valid/sig/done got %b%b%b%b want 0000",
                     name, busy, seq_valid, seq_signal, done);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #12;
        expect_quiet("reset_state");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        expect_quiet("after_reset_release");
    endtask

    task automatic test_detect_pattern();
        expect_xfer(7'b1110010, 8'd1, 4'd1, 1'b0, "detect");
        step();
        expect_quiet("detect_idle");
    endtask

    task automatic test_bit_divider();
        expect_xfer(7'b1010101, 8'd3, 4'd2, 1'b0, "div3_rpt2");
        step();
        expect_quiet("div3_idle");
    endtask

    task automatic test_zero_params();
        expect_xfer(7'b0110011, 8'd0, 4'd0, 1'b0, "zero_params");
        step();
        expect_quiet("zero_idle");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            expect_xfer(W'($urandom), DW'($urandom_range(0, 4)), RW'($urandom_range(0, 3)),
                        1'b0, "random");
            step();
        end
    endtask

    task automatic test_disturb_and_back_to_back();
        expect_xfer(7'b1100101, 8'd2, 4'd2, 1'b1, "disturb");
        expect_xfer(7'b0011010, 8'd1, 4'd1, 1'b0, "back_to_back");
        expect_xfer(7'b1000001, 8'd2, 4'd1, 1'b0, "back_to_back2");
        step();
        expect_quiet("b2b_idle");
    endtask

    task automatic test_abort();
        logic [W-1:0] pat;
        pat = 7'b1011011;
        start = 1'b1; pattern_in = pat; bit_div = 8'd2; repeat_cnt = 4'd1;
        step();
        start = 1'b0;
        // bits 0..2 span cycles 0..5; abort goes up on the first cycle of bit 3
        for (int j = 0; j < 7; j++) begin
            vectors++;
            if ({busy, seq_valid, seq_signal} !== {2'b11, pat[W - 1 - j / 2]}) begin
                errors++;
                $display("FAIL abort_pre cyc %0d: busy/valid/sig got %b%b%b want 11%b",
                         j, busy, seq_valid, seq_signal, pat[W - 1 - j / 2]);
            end
            if (j == 6) abort = 1'b1;
            else step();
        end
        step();
        abort = 1'b0;
        expect_quiet("abort_outputs");
        for (int j = 0; j < 16; j++) begin
            step();
            expect_quiet("abort_no_done");
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_quiet("abort_idle");
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        expect_quiet("abort_start_priority");
        step();
        expect_quiet("abort_start_priority2");
        expect_xfer(7'b0101100, 8'd1, 4'd1, 1'b0, "after_abort");
        step();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; pattern_in = 7'b1111111; bit_div = 8'd3; repeat_cnt = 4'd3;
        step();
        start = 1'b0;
        repeat (5) step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        expect_quiet("async_reset");
        #4;
        sys_rst_n = 1'b1;
        step();
        expect_quiet("reset_release_idle");
        expect_xfer(7'b0100110, 8'd2, 4'd1, 1'b0, "after_reset");
        step();
    endtask

    task automatic test_max();
        expect_xfer(7'b1001011, 8'd255, 4'd15, 1'b0, "max_params");
        step();
        expect_quiet("max_idle");
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; pattern_in = '0; bit_div = '0; repeat_cnt = '0;
        test_reset();
        test_detect_pattern();
        test_bit_divider();
        test_zero_params();
        test_random();
        test_disturb_and_back_to_back();
        test_abort();
        test_reset_mid();
        test_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: loads a WIDTH-bit pattern on a start request and shifts it out MSB-first on a single-bit line. Each bit is held for a programmable number of clocks, and the whole pattern repeats a programmable number of times. It is the driving end of the serial sequence-detection path: its `seq_signal` output feeds the detector's `seq_signal` input, so test and demo designs can emit target sequences on command.

## Interface
- `WIDTH`, default 7: pattern length in bits.
- `DIV_W`, default 16: width of the bit-period input.
- `RPT_W`, default 8: width of the repeat-count input.
- `sys_clk`  in  1: system clock, rising edge.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: transmit request; sampled only when idle.
- `abort`  in  1: synchronous cancel of a transfer in progress.
- `pattern_in`  in  WIDTH: pattern to send; bit WIDTH-1 is sent first.
- `bit_div`  in  DIV_W: clocks per bit; 0 is treated as 1.
- `repeat_cnt`  in  RPT_W: pattern repetitions; 0 is treated as 1.
- `seq_signal`  out  1: serial data, registered.
- `seq_valid`  out  1: high while `seq_signal` carries a pattern bit.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- FSM has two states: IDLE and SEND.
- IDLE:
  - `seq_signal`=0, `seq_valid`=0, `busy`=0.
  - `start`=1 latches `pattern_in`, D=max(`bit_div`,1) and R=max(`repeat_cnt`,1) into internal registers, then enters SEND.
- SEND:
  - Shift register drives `seq_signal` = current MSB; `seq_valid`=1, `busy`=1.
  - Bit counter counts D clocks per bit, then shifts left by one.
  - After WIDTH bits, the latched pattern is reloaded and the repeat counter decrements.
  - After the last bit of repetition R, the FSM returns to IDLE and pulses `done`.
- Inputs are not tracked during a transfer:
  - `start` is ignored while in SEND.
  - Changes to `pattern_in`, `bit_div` and `repeat_cnt` during SEND have no effect until the next accepted start.
- Abort:
  - `abort`=1 in SEND returns the FSM to IDLE on the next edge; `done` is not pulsed.
  - `abort` in IDLE has no effect.
  - `abort` and `start` high together in IDLE: `abort` has priority, and the start is dropped.
- Reset:
  - Asserting `sys_rst_n` mid-transfer forces IDLE immediately (asynchronous).
  - All internal counters and shift state clear.
  - No `done` pulse is produced.
- Reset values: `seq_signal`=0, `seq_valid`=0, `busy`=0, `done`=0.
- Counter widths:
  - Bit counter: DIV_W bits.
  - Repeat counter: RPT_W bits.
  - Bit index: ceil(log2(WIDTH+1)) bits.
  - No counter wraps within a legal transfer. Maximum values (`bit_div` = 2^DIV_W-1, `repeat_cnt` = 2^RPT_W-1) must complete correctly.

## Timing
- Start sampled high at edge N (IDLE): `busy`, `seq_valid` and MSB on `seq_signal` are all valid after edge N+1.
- Each bit occupies exactly D cycles. A transfer holds `busy`=1 for exactly WIDTH·D·R cycles.
- Completion, in the cycle after the last bit period:
  - `busy`=0, `seq_valid`=0, `seq_signal`=0, `done`=1 for one cycle.
  - The FSM is in IDLE, so a `start` in this cycle is accepted. The back-to-back gap between transfers is one cycle.
- Repetitions are seamless: the last bit of repetition k is followed directly by the MSB of repetition k+1, with no idle cycle.
- Abort sampled at edge M: `busy`, `seq_valid` and `seq_signal` are 0 after edge M+1.
- With D=1 and R=1, the output is bit-for-bit aligned to one bit per clock, matching a detector that samples every clock.

## Test plan
- Detection pattern:
  - Stimulus: reset, then `pattern_in`=7'b1110010, `bit_div`=1, `repeat_cnt`=1, start pulse.
  - Response: `seq_signal` = 1,1,1,0,0,1,0 on cycles N+1..N+7; `busy` high for 7 cycles; `done`=1 on N+8; connected detector drives its LED low.
- Bit divider:
  - Stimulus: `bit_div`=3, `repeat_cnt`=2, pattern 7'b1010101.
  - Response: each bit held 3 cycles; 42 busy cycles; no gap between repetitions; single `done` pulse.
- Zero parameters:
  - Stimulus: `bit_div`=0, `repeat_cnt`=0.
  - Response: behaves as D=1, R=1, with 7 busy cycles.
- Start and input changes during SEND:
  - Stimulus: pulse `start` and change `pattern_in` mid-transfer.
  - Response: transfer continues with the original pattern; no restart. A start in the `done` cycle begins a new transfer the next cycle.
- Abort:
  - Stimulus: `abort` asserted on the 4th bit of a D=2 transfer.
  - Response: outputs 0 one cycle later; no `done`; next start is accepted normally.
- Reset mid-transfer:
  - Stimulus: `sys_rst_n` low mid-bit, asynchronous to the clock.
  - Response: `seq_signal`, `seq_valid`, `busy` and `done` go to 0 immediately; after release, a new transfer is clean from its MSB.
